pifo_sched_ctrl: RTL
====================

PIFO_SCHED_CTRL -- requirements
Module: pifo_sched_ctrl

Interface
REQ-001 Parameter RANK_WIDTH, default 8, rank field width.
REQ-002 Parameter META_WIDTH, default 8, metadata field width.
REQ-003 Parameter CNT_WIDTH, default 16, statistics counter width.
REQ-004 Clocking and reset SHALL be: one clock; reset is synchronous and active-low.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  synchronous reset, active-low.
REQ-007 enq0_valid / enq1_valid  in  1 each  requester 0/1 enqueue request.
REQ-008 enq0_rank / enq1_rank  in  RANK_WIDTH each  requester rank.
REQ-009 enq0_meta / enq1_meta  in  META_WIDTH each  requester metadata.
REQ-010 enq0_ready / enq1_ready  out  1 each  enqueue accepted this cycle.
REQ-011 deq_req  in  1  dequeue request, level, held until deq_valid.
REQ-012 deq_valid  out  1  one-cycle pulse, dequeued entry on deq_rank/deq_meta.
REQ-013 deq_rank / deq_meta  out  RANK_WIDTH / META_WIDTH  dequeued entry.
REQ-014 pifo_rst  out  1  active-high reset to the PIFO register, equal to !rst.
REQ-015 pifo_insert / pifo_remove  out  1 each  PIFO operation strobes.
REQ-016 pifo_rank_in / pifo_meta_in  out  RANK_WIDTH / META_WIDTH  PIFO insert data.
REQ-017 pifo_rank_out / pifo_meta_out / pifo_valid_out  in  RANK_WIDTH / META_WIDTH / 1  PIFO current minimum.
REQ-018 pifo_max_rank_out / pifo_full  in  RANK_WIDTH / 1  PIFO current maximum rank, full flag.
REQ-019 enq_cnt / deq_cnt / drop_cnt  out  CNT_WIDTH each  accepted, dequeued, dropped counts.

Function
REQ-020 FSM states SHALL be IDLE, SETTLE; an operation may only be issued in IDLE.
REQ-021 On issue, the FSM SHALL go IDLE->SETTLE; SETTLE->IDLE unconditionally the next cycle; no issue in SETTLE.
REQ-022 pifo_insert/pifo_remove SHALL be high for exactly the issue cycle only; min spacing between issues is 2 cycles.
REQ-023 In IDLE, PIFO is non-empty iff pifo_valid_out=1; pifo_empty is not used.
REQ-024 Enqueue arbitration SHALL be round-robin: last-granted pointer starts at 1 (port 0 first after reset); it toggles to the granted port on each grant.
REQ-025 Grant rule in IDLE: enqN_ready=1 for the selected pending port only, in the issue cycle; a port is never readied in SETTLE.
REQ-026 Dequeue only (deq_req=1, no enqueue pending, pifo_valid_out=1): pifo_remove=1.
REQ-027 Enqueue only (no eligible dequeue): pifo_insert=1 with granted rank/meta.
REQ-028 Both pending, pifo_valid_out=1, granted rank >= pifo_rank_out: pifo_insert=pifo_remove=1 (replace-min) in one issue.
REQ-029 Both pending, granted rank < pifo_rank_out: enqueue only; dequeue waits.
REQ-030 deq_req with pifo_valid_out=0: no remove, request stays pending, no deq_valid.
REQ-031 deq_valid SHALL rise the cycle after remove issue (the SETTLE cycle), with deq_rank/deq_meta = pifo_rank_out/pifo_meta_out registered at issue.
REQ-032 Full drop: insert with pifo_full=1 and rank >= pifo_max_rank_out: handshake completes, drop_cnt+1, enq_cnt unchanged.
REQ-033 Otherwise every accepted enqueue increments enq_cnt (displacement of the max by a smaller rank is not a drop).
REQ-034 Every remove issue increments deq_cnt.
REQ-035 Counters SHALL wrap modulo 2^CNT_WIDTH.
REQ-036 Replace-min under pifo_full=1 SHALL NOT count as drop; occupancy unchanged.

Reset
REQ-037 While rst=0: state IDLE, RR pointer=1, all ready/valid/strobe outputs 0, deq_rank/deq_meta 0, counters 0, pifo_rst=1.
REQ-038 Reset mid-operation (SETTLE or pending deq_valid) SHALL abort; no deq_valid or counter update on the cycle after reset release.
REQ-039 First issue allowed in the IDLE cycle after release, gated by pifo_valid_out as usual.

Verification
REQ-040 Enqueue ranks 5,3,9 on port 0, then deq_req x3 -> deq_valid pulses with ranks 3,5,9; enq_cnt=3, deq_cnt=3.
REQ-041 enq0/enq1 both valid continuously -> grants alternate 0,1,0,1 at 2-cycle spacing, port 0 first.
REQ-042 PIFO holding {4}, deq_req with enq0 rank 7 -> single issue with insert=remove=1, deq_rank=4; with rank 2 instead -> insert only, next op dequeues 2.
REQ-043 PIFO full with max 20: enqueue rank 25 -> drop_cnt=1, enq_cnt unchanged; enqueue rank 10 -> enq_cnt+1, drop_cnt unchanged.
REQ-044 deq_req on empty PIFO -> no remove/deq_valid; enqueue rank 6 -> dequeue issued at the next IDLE after SETTLE, deq_rank=6.
REQ-045 Assert rst=0 during SETTLE after a remove -> no deq_valid, counters 0, ready outputs 0.

Source files
------------

// File: rtl/pifo_sched_ctrl.sv
// Arbitrates two enqueue ports and a dequeue port onto a single-op-per-window PIFO register.
// Ops issue only in IDLE and are followed by one SETTLE cycle; deq_valid pulses in that SETTLE cycle.
module pifo_sched_ctrl #(
  parameter int RANK_WIDTH = 8,
  parameter int META_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enq0_valid,
  input  logic [RANK_WIDTH-1:0] enq0_rank,
  input  logic [META_WIDTH-1:0] enq0_meta,
  output logic                  enq0_ready,
  input  logic                  enq1_valid,
  input  logic [RANK_WIDTH-1:0] enq1_rank,
  input  logic [META_WIDTH-1:0] enq1_meta,
  output logic                  enq1_ready,
  input  logic                  deq_req,
  output logic                  deq_valid,
  output logic [RANK_WIDTH-1:0] deq_rank,
  output logic [META_WIDTH-1:0] deq_meta,
  output logic                  pifo_rst,
  output logic                  pifo_insert,
  output logic                  pifo_remove,
  output logic [RANK_WIDTH-1:0] pifo_rank_in,
  output logic [META_WIDTH-1:0] pifo_meta_in,
  input  logic [RANK_WIDTH-1:0] pifo_rank_out,
  input  logic [META_WIDTH-1:0] pifo_meta_out,
  input  logic                  pifo_valid_out,
  input  logic [RANK_WIDTH-1:0] pifo_max_rank_out,
  input  logic                  pifo_full,
  output logic [CNT_WIDTH-1:0]  enq_cnt,
  output logic [CNT_WIDTH-1:0]  deq_cnt,
  output logic [CNT_WIDTH-1:0]  drop_cnt
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] SETTLE = 1'b1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [0:0]            state;
  logic                  rr_last;
  logic                  sel;
  logic [RANK_WIDTH-1:0] sel_rank;
  logic [META_WIDTH-1:0] sel_meta;
  logic                  enq_pend;
  logic                  idle_ok;
  logic                  do_ins;
  logic                  do_rem;
  logic                  drop;
  logic                  deq_valid_q;
  logic [RANK_WIDTH-1:0] deq_rank_q;
  logic [META_WIDTH-1:0] deq_meta_q;
  logic [CNT_WIDTH-1:0]  enq_cnt_q;
  logic [CNT_WIDTH-1:0]  deq_cnt_q;
  logic [CNT_WIDTH-1:0]  drop_cnt_q;

  always_comb begin
    enq_pend = enq0_valid | enq1_valid;
    sel      = (enq0_valid && enq1_valid) ? ~rr_last : enq1_valid;
    sel_rank = sel ? enq1_rank : enq0_rank;
    sel_meta = sel ? enq1_meta : enq0_meta;
    idle_ok  = rst && (state == IDLE);
    do_ins   = idle_ok && enq_pend;
    // A pending enqueue smaller than the head must land first, so the dequeue waits.
    do_rem   = idle_ok && deq_req && pifo_valid_out &&
               (!enq_pend || (sel_rank >= pifo_rank_out));
    // Replace-min keeps occupancy constant, so it can never overflow.
    drop     = do_ins && !do_rem && pifo_full && (sel_rank >= pifo_max_rank_out);
  end

  assign enq0_ready   = do_ins && !sel;
  assign enq1_ready   = do_ins && sel;
  assign pifo_insert  = do_ins;
  assign pifo_remove  = do_rem;
  assign pifo_rank_in = sel_rank;
  assign pifo_meta_in = sel_meta;
  assign pifo_rst     = !rst;

  // Held-low reset blanks registered outputs immediately, even mid-SETTLE.
  assign deq_valid = rst & deq_valid_q;
  assign deq_rank  = rst ? deq_rank_q : '0;
  assign deq_meta  = rst ? deq_meta_q : '0;
  assign enq_cnt   = rst ? enq_cnt_q  : '0;
  assign deq_cnt   = rst ? deq_cnt_q  : '0;
  assign drop_cnt  = rst ? drop_cnt_q : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      rr_last     <= 1'b1;
      deq_valid_q <= 1'b0;
      deq_rank_q  <= '0;
      deq_meta_q  <= '0;
      enq_cnt_q   <= '0;
      deq_cnt_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      case (state)
        IDLE:    if (do_ins || do_rem) state <= SETTLE;
        SETTLE:  state <= IDLE;
        default: state <= IDLE;
      endcase
      deq_valid_q <= do_rem;
      if (do_rem) begin
        deq_rank_q <= pifo_rank_out;
        deq_meta_q <= pifo_meta_out;
        deq_cnt_q  <= deq_cnt_q + CNT_ONE;
      end
      if (do_ins) begin
        rr_last <= sel;
        if (drop) drop_cnt_q <= drop_cnt_q + CNT_ONE;
        else      enq_cnt_q  <= enq_cnt_q + CNT_ONE;
      end
    end
  end

endmodule
